tmds_link_sequencer: RTL and testbench

Pixel-clock-domain bring-up and channel controller for the three 10:1 TMDS serializers.
- Watches the PLL lock signal and holds the serializers in reset until the clocks are stable.
- Drives a fixed DVI control-token training burst, then switches the three TMDS channels over to the encoder outputs.
- Sits between the TMDS encoders and the serializer instances; its reset and word outputs connect directly to the serializers' reset and data inputs.

---
 rtl/tmds_link_sequencer.sv | 123 ++++++++++++
 tb/tb_tmds_link_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tmds_link_sequencer.sv
// Bring-up sequencer for the three TMDS serializers: qualifies PLL lock, holds the serializers
// in reset, sends a control-token training burst, then forwards encoder words. Option: LINK_RELOCK_COUNT_EN.
module tmds_link_sequencer #(
    parameter int LOCK_CYCLES    = 1024,
    parameter int SER_RST_CYCLES = 16,
    parameter int TRAIN_CYCLES   = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clk_lock,
    input  logic       i_retrain,
    input  logic [9:0] i_tmds_ch0,
    input  logic [9:0] i_tmds_ch1,
    input  logic [9:0] i_tmds_ch2,
    output logic [9:0] o_tmds_ch0,
    output logic [9:0] o_tmds_ch1,
    output logic [9:0] o_tmds_ch2,
    output logic       o_ser_rst,
    output logic       o_link_up,
    output logic [1:0] o_state
`ifdef LINK_RELOCK_COUNT_EN
    ,
    output logic [7:0] o_relock_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_LOCK_WAIT = 2'd0,
        ST_SER_RST   = 2'd1,
        ST_TRAIN     = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    localparam logic [9:0]  TOKEN      = 10'b1101010100;
    localparam logic [15:0] LOCK_LAST  = 16'(LOCK_CYCLES - 1);
    localparam logic [15:0] SER_LAST   = 16'(SER_RST_CYCLES - 1);
    localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_CYCLES - 1);

    logic        lock_meta_q;
    logic        lock_s_q;
    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ser_rst_q;
    logic        link_up_q;
    logic [9:0]  ch0_q, ch1_q, ch2_q;
    logic        fwd_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= i_clk_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 16'd1;
        case (state_q)
            ST_LOCK_WAIT: begin
                if (!lock_s_q)              cnt_d   = 16'd0;
                else if (cnt_q == LOCK_LAST) state_d = ST_SER_RST;
            end
            ST_SER_RST: if (cnt_q == SER_LAST)   state_d = ST_TRAIN;
            ST_TRAIN:   if (cnt_q == TRAIN_LAST) state_d = ST_RUN;
            ST_RUN: begin
                cnt_d = cnt_q;
                if (i_retrain) state_d = ST_TRAIN;
            end
            default: state_d = ST_LOCK_WAIT;
        endcase
        // Losing lock outranks retrain requests and counter expiry.
        if (state_q != ST_LOCK_WAIT && !lock_s_q) state_d = ST_LOCK_WAIT;
        if (state_d != state_q) cnt_d = 16'd0;
    end

    // Forward encoder words only while RUN is stable; the token goes out on the edge that drops lock.
    assign fwd_d = (state_q == ST_RUN) && lock_s_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_LOCK_WAIT;
            cnt_q     <= 16'd0;
            ser_rst_q <= 1'b1;
            link_up_q <= 1'b0;
            ch0_q     <= TOKEN;
            ch1_q     <= TOKEN;
            ch2_q     <= TOKEN;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ser_rst_q <= (state_d == ST_LOCK_WAIT) || (state_d == ST_SER_RST);
            link_up_q <= (state_d == ST_RUN);
            ch0_q     <= fwd_d ? i_tmds_ch0 : TOKEN;
            ch1_q     <= fwd_d ? i_tmds_ch1 : TOKEN;
            ch2_q     <= fwd_d ? i_tmds_ch2 : TOKEN;
        end
    end

`ifdef LINK_RELOCK_COUNT_EN
    logic [7:0] relock_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            relock_q <= 8'd0;
        end else if (state_q != ST_LOCK_WAIT && state_d == ST_LOCK_WAIT && relock_q != 8'hFF) begin
            relock_q <= relock_q + 8'd1;
        end
    end

    assign o_relock_cnt = relock_q;
`endif

    assign o_ser_rst  = ser_rst_q;
    assign o_link_up  = link_up_q;
    assign o_state    = state_q;
    assign o_tmds_ch0 = ch0_q;
    assign o_tmds_ch1 = ch1_q;
    assign o_tmds_ch2 = ch2_q;

endmodule

// File: tb/tb_tmds_link_sequencer.sv
// Directed bench for tmds_link_sequencer with LOCK_CYCLES=8, SER_RST_CYCLES=4, TRAIN_CYCLES=6.
module tb_tmds_link_sequencer;

    localparam logic [9:0]  TOKEN = 10'b1101010100;
    localparam logic [29:0] TOK3  = {TOKEN, TOKEN, TOKEN};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       retrain = 1'b0;
    logic [9:0] in0 = 10'h1A6;
    logic [9:0] in1 = 10'h259;
    logic [9:0] in2 = 10'h302;
    logic [9:0] out0, out1, out2;
    logic       ser_rst, link_up;
    logic [1:0] state;
`ifdef LINK_RELOCK_COUNT_EN
    logic [7:0] relock;
`endif

    int n_checks = 0;
    int n_errors = 0;

    tmds_link_sequencer #(
        .LOCK_CYCLES(8),
        .SER_RST_CYCLES(4),
        .TRAIN_CYCLES(6)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_clk_lock(lock),
        .i_retrain(retrain),
        .i_tmds_ch0(in0),
        .i_tmds_ch1(in1),
        .i_tmds_ch2(in2),
        .o_tmds_ch0(out0),
        .o_tmds_ch1(out1),
        .o_tmds_ch2(out2),
        .o_ser_rst(ser_rst),
        .o_link_up(link_up),
        .o_state(state)
`ifdef LINK_RELOCK_COUNT_EN
        ,
        .o_relock_cnt(relock)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; lock = 1'b0; retrain = 1'b0;
        in0 = 10'h1A6; in1 = 10'h259; in2 = 10'h302;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic bring_up();
        int n;
        do_reset();
        lock = 1'b1;
        n = 0;
        while (!link_up && n < 60) begin
            tick();
            n++;
        end
        check_eq("bring_up_link", {31'd0, link_up}, 32'd1);
        tick();
    endtask

    logic [29:0] vec [4] = '{30'h0000_0000, 30'h3FFF_FFFF, 30'h1234_5678, 30'h2AAA_5555};

    initial begin
        logic [1:0]  st_exp;
        logic [29:0] tm_exp;
        int          a;

        // Reset values
        rst = 1'b1;
        #12;
        check_eq("rst_ser_rst", {31'd0, ser_rst}, 32'd1);
        check_eq("rst_link_up", {31'd0, link_up}, 32'd0);
        check_eq("rst_state", {30'd0, state}, 32'd0);
        check_eq("rst_tmds", {2'd0, out2, out1, out0}, {2'd0, TOK3});

        // Bring-up: edge 1 is the first edge sampling lock=1
        do_reset();
        lock = 1'b1;
        for (int e = 1; e <= 22; e++) begin
            tick();
            st_exp = (e < 10) ? 2'd0 : (e < 14) ? 2'd1 : (e < 20) ? 2'd2 : 2'd3;
            tm_exp = (e >= 21) ? {10'h302, 10'h259, 10'h1A6} : TOK3;
            check_eq($sformatf("up_ser_rst_e%0d", e), {31'd0, ser_rst}, {31'd0, e < 14});
            check_eq($sformatf("up_link_e%0d", e), {31'd0, link_up}, {31'd0, e >= 20});
            check_eq($sformatf("up_state_e%0d", e), {30'd0, state}, {30'd0, st_exp});
            check_eq($sformatf("up_tmds_e%0d", e), {2'd0, out2, out1, out0}, {2'd0, tm_exp});
        end

        // One-cycle latency in RUN
        for (int k = 0; k < 4; k++) begin
            {in2, in1, in0} = vec[k];
            tick();
            check_eq($sformatf("run_latency_%0d", k), {2'd0, out2, out1, out0}, {2'd0, vec[k]});
        end
        {in2, in1, in0} = {10'h302, 10'h259, 10'h1A6};
        tick();

        // Lock loss in RUN: outputs change on the third edge after lock drops
        lock = 1'b0;
        tick();
        check_eq("loss_link_a0", {31'd0, link_up}, 32'd1);
        tick();
        check_eq("loss_link_a1", {31'd0, link_up}, 32'd1);
        check_eq("loss_tmds_a1", {2'd0, out2, out1, out0}, {2'd0, 10'h302, 10'h259, 10'h1A6});
        tick();
        check_eq("loss_ser_rst", {31'd0, ser_rst}, 32'd1);
        check_eq("loss_link", {31'd0, link_up}, 32'd0);
        check_eq("loss_state", {30'd0, state}, 32'd0);
        check_eq("loss_tmds", {2'd0, out2, out1, out0}, {2'd0, TOK3});
`ifdef LINK_RELOCK_COUNT_EN
        check_eq("loss_relock", {24'd0, relock}, 32'd1);
`endif

        // Lock glitch at edge 6 restarts qualification
        do_reset();
        lock = 1'b1;
        for (int e = 1; e <= 26; e++) begin
            if (e == 6) lock = 1'b0;
            if (e == 7) lock = 1'b1;
            tick();
            st_exp = (e < 16) ? 2'd0 : (e < 20) ? 2'd1 : (e < 26) ? 2'd2 : 2'd3;
            check_eq($sformatf("glitch_state_e%0d", e), {30'd0, state}, {30'd0, st_exp});
            check_eq($sformatf("glitch_ser_rst_e%0d", e), {31'd0, ser_rst}, {31'd0, e < 20});
        end
`ifdef LINK_RELOCK_COUNT_EN
        check_eq("glitch_relock", {24'd0, relock}, 32'd0);
`endif

        // Retrain in RUN, plus an ignored retrain during TRAIN
        bring_up();
        retrain = 1'b1;
        tick();
        retrain = 1'b0;
        check_eq("rt_link_e0", {31'd0, link_up}, 32'd0);
        check_eq("rt_state_e0", {30'd0, state}, 32'd2);
        check_eq("rt_tmds_e0", {2'd0, out2, out1, out0}, {2'd0, 10'h302, 10'h259, 10'h1A6});
        for (int k = 1; k <= 6; k++) begin
            if (k == 2) retrain = 1'b1;
            tick();
            retrain = 1'b0;
            check_eq($sformatf("rt_link_e%0d", k), {31'd0, link_up}, {31'd0, k == 6});
            check_eq($sformatf("rt_ser_rst_e%0d", k), {31'd0, ser_rst}, 32'd0);
            check_eq($sformatf("rt_tmds_e%0d", k), {2'd0, out2, out1, out0}, {2'd0, TOK3});
        end
        tick();
        check_eq("rt_tmds_back", {2'd0, out2, out1, out0}, {2'd0, 10'h302, 10'h259, 10'h1A6});
        check_eq("rt_state_back", {30'd0, state}, 32'd3);

        // Retrain on the same edge lock_s is seen low
        bring_up();
        lock = 1'b0;
        tick();
        tick();
        retrain = 1'b1;
        tick();
        retrain = 1'b0;
        check_eq("simul_state", {30'd0, state}, 32'd0);
        check_eq("simul_ser_rst", {31'd0, ser_rst}, 32'd1);
        check_eq("simul_link", {31'd0, link_up}, 32'd0);
`ifdef LINK_RELOCK_COUNT_EN
        check_eq("simul_relock", {24'd0, relock}, 32'd1);
`endif
        a = 0;
        repeat (3) begin
            tick();
            if (state != 2'd0) a++;
        end
        check_eq("simul_stays_lockwait", a, 32'd0);

        // Asynchronous reset between edges while in RUN
        bring_up();
        check_eq("arst_pre_state", {30'd0, state}, 32'd3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_ser_rst", {31'd0, ser_rst}, 32'd1);
        check_eq("arst_link", {31'd0, link_up}, 32'd0);
        check_eq("arst_state", {30'd0, state}, 32'd0);
        check_eq("arst_tmds", {2'd0, out2, out1, out0}, {2'd0, TOK3});
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
